// File: rtl/rf_pkg.sv
// Shared widths, state encoding and write-payload type for the register-file write arbiter.
package rf_pkg;

    localparam int unsigned REG_ADDR_W           = 5;
    localparam int unsigned REG_DATA_W           = 32;
    localparam int unsigned WAIT_CNT_W           = 4;
    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_STALL = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/condmov_resolve.sv
// Resolves whether the WB-stage instruction really writes the register file.
// Conditional moves (movz/movn) are honoured only when RF_CONDMOV_EN is defined.
module condmov_resolve (
    input  logic reg_write,
    input  logic cond_mov,
    input  logic mov_n,
    input  logic zero,
    output logic eff_write_c
);

`ifdef RF_CONDMOV_EN
    assign eff_write_c = reg_write && (!cond_mov || (mov_n ? !zero : zero));
`else
    logic unused_condmov;
    assign unused_condmov = cond_mov ^ mov_n ^ zero;
    assign eff_write_c    = reg_write;
`endif

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between the WB pipeline and a multi-cycle unit,
// stalling the pipeline when the secondary starves. Conditional moves need RF_CONDMOV_EN.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  PipeRegWrite,
    input  logic                  PipeCondMov,
    input  logic                  PipeMovN,
    input  logic                  PipeZero,
    input  logic [REG_ADDR_W-1:0] PipeAddr,
    input  logic [REG_DATA_W-1:0] PipeData,
    input  logic                  SecValid,
    input  logic [REG_ADDR_W-1:0] SecAddr,
    input  logic [REG_DATA_W-1:0] SecData,
    output logic                  SecReady,
    output logic                  RfWrite,
    output logic [REG_ADDR_W-1:0] RfAddr,
    output logic [REG_DATA_W-1:0] RfData,
    output logic                  PipeStall
);

    arb_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_q, wait_d;
    logic                  rf_write_q, rf_write_d;
    rf_wr_t                rf_q, rf_d;
    logic                  pipe_stall_q, pipe_stall_d;

    logic   pipe_eff_c;
    logic   sec_ready_c;
    logic   sec_xfer_c;
    logic   win_c;
    rf_wr_t win_req_c;

    condmov_resolve u_condmov (
        .reg_write   (PipeRegWrite),
        .cond_mov    (PipeCondMov),
        .mov_n       (PipeMovN),
        .zero        (PipeZero),
        .eff_write_c (pipe_eff_c)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter STALL once the secondary has waited STARVE_LIMIT cycles
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (32'(wait_d) >= STARVE_LIMIT) state_d = ARB_STALL;
            ARB_STALL: if (sec_xfer_c || !SecValid) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
        pipe_stall_d = (state_d == ARB_STALL);
    end

    // Outputs: grant and selection of the write-port winner
    always_comb begin
        sec_ready_c = 1'b0;
        win_c       = 1'b0;
        win_req_c   = rf_q;
        case (state_q)
            ARB_IDLE: begin
                if (pipe_eff_c) begin
                    win_c     = 1'b1;
                    win_req_c = '{addr: PipeAddr, data: PipeData};
                end else if (SecValid) begin
                    sec_ready_c = 1'b1;
                    win_c       = 1'b1;
                    win_req_c   = '{addr: SecAddr, data: SecData};
                end
            end
            ARB_STALL: begin
                if (SecValid) begin
                    sec_ready_c = 1'b1;
                    win_c       = 1'b1;
                    win_req_c   = '{addr: SecAddr, data: SecData};
                end
            end
            default: ;
        endcase
        if (Reset) begin
            sec_ready_c = 1'b0;
        end
        sec_xfer_c = SecValid && sec_ready_c;
        rf_write_d = win_c && (win_req_c.addr != '0);
        rf_d       = win_c ? win_req_c : rf_q;
    end

    // Starvation counter: counts refused cycles, clears on transfer or withdrawal
    always_comb begin
        wait_d = wait_q;
        if (!SecValid || sec_xfer_c) begin
            wait_d = '0;
        end else if (wait_q != '1) begin
            wait_d = wait_q + WAIT_CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_q       <= '0;
            rf_write_q   <= 1'b0;
            rf_q         <= '0;
            pipe_stall_q <= 1'b0;
        end else begin
            wait_q       <= wait_d;
            rf_write_q   <= rf_write_d;
            rf_q         <= rf_d;
            pipe_stall_q <= pipe_stall_d;
        end
    end

    assign SecReady  = sec_ready_c;
    assign RfWrite   = rf_write_q;
    assign RfAddr    = rf_q.addr;
    assign RfData    = rf_q.data;
    assign PipeStall = pipe_stall_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized self-checking bench for rf_write_arbiter against a cycle-level reference model.
module tb_rf_write_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        PipeRegWrite, PipeCondMov, PipeMovN, PipeZero;
    logic [4:0]  PipeAddr;
    logic [31:0] PipeData;
    logic        SecValid;
    logic [4:0]  SecAddr;
    logic [31:0] SecData;
    logic        SecReady, RfWrite, PipeStall;
    logic [4:0]  RfAddr;
    logic [31:0] RfData;

    always #5 Clk = ~Clk;

    rf_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .PipeRegWrite (PipeRegWrite),
        .PipeCondMov  (PipeCondMov),
        .PipeMovN     (PipeMovN),
        .PipeZero     (PipeZero),
        .PipeAddr     (PipeAddr),
        .PipeData     (PipeData),
        .SecValid     (SecValid),
        .SecAddr      (SecAddr),
        .SecData      (SecData),
        .SecReady     (SecReady),
        .RfWrite      (RfWrite),
        .RfAddr       (RfAddr),
        .RfData       (RfData),
        .PipeStall    (PipeStall)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: how long the secondary has been refused, and the expected port contents
    int          m_wait     = 0;
    bit          m_stalled  = 1'b0;
    bit          m_xfer     = 1'b0;
    bit          m_ready    = 1'b0;
    bit          m_write    = 1'b0;
    bit          m_stall    = 1'b0;
    bit          m_ad_valid = 1'b0;
    logic [4:0]  m_addr     = '0;
    logic [31:0] m_data     = '0;

    task automatic cyc(input bit rst, input bit prw, input bit pcm, input bit pmn, input bit pz,
                       input logic [4:0] pa, input logic [31:0] pd,
                       input bit sv, input logic [4:0] sa, input logic [31:0] sd);
        bit          eff;
        bit          won;
        logic [4:0]  wa;
        logic [31:0] wd;
        @(negedge Clk);
        Reset = rst; PipeRegWrite = prw; PipeCondMov = pcm; PipeMovN = pmn; PipeZero = pz;
        PipeAddr = pa; PipeData = pd; SecValid = sv; SecAddr = sa; SecData = sd;
        #1;
`ifdef RF_CONDMOV_EN
        eff = prw && (!pcm || (pmn ? !pz : pz));
`else
        eff = prw;
`endif
        if (rst) begin
            m_ready = 1'b0; m_xfer = 1'b0; m_write = 1'b0;
            m_ad_valid = 1'b1; m_addr = '0; m_data = '0;
            m_wait = 0; m_stalled = 1'b0;
        end else begin
            m_ready = sv && (m_stalled || !eff);
            m_xfer  = sv && m_ready;
            won = 1'b1; wa = pa; wd = pd;
            if (!(!m_stalled && eff)) begin
                won = m_xfer; wa = sa; wd = sd;
            end
            m_write = won && (wa != 5'd0);
            if (won) begin
                m_ad_valid = (wa != 5'd0);
                if (wa != 5'd0) begin
                    m_addr = wa; m_data = wd;
                end
            end
            m_wait    = (sv && !m_ready) ? m_wait + 1 : 0;
            m_stalled = (m_wait >= int'(LIMIT));
        end
        m_stall = m_stalled;
        check_eq("sec_ready", 32'(SecReady), 32'(m_ready));
        @(posedge Clk);
        #1;
        check_eq("rf_write", 32'(RfWrite), 32'(m_write));
        check_eq("pipe_stall", 32'(PipeStall), 32'(m_stall));
        if (m_ad_valid) begin
            check_eq("rf_addr", 32'(RfAddr), 32'(m_addr));
            check_eq("rf_data", RfData, m_data);
        end
    endtask

    initial begin
        bit          c_sv;
        logic [4:0]  c_sa;
        logic [31:0] c_sd;
        c_sv = 1'b0; c_sa = '0; c_sd = '0;

        // Reset, with a secondary request pending that must not be granted
        cyc(1, 0, 0, 0, 0, 5'd0, 32'h0, 1, 5'd3, 32'h33);
        cyc(1, 0, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        // Plain pipeline write
        cyc(0, 1, 0, 0, 0, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
        check_eq("plain_addr", 32'(RfAddr), 32'd5);
        check_eq("plain_data", RfData, 32'hDEADBEEF);

        // Failed movz lets the secondary through (pipe wins without the conditional-move feature)
        cyc(0, 1, 1, 0, 0, 5'd9, 32'h99, 1, 5'd7, 32'h12);
        cyc(0, 0, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        // Starvation: four refused cycles, then stall, transfer, release
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 0, 0, 5'(i + 1), 32'(i), 1, 5'd9, 32'hABC);
            if (i == 3) check_eq("stall_after_4", 32'(PipeStall), 32'd1);
        end
        check_eq("starved_addr", 32'(RfAddr), 32'd9);
        check_eq("stall_released", 32'(PipeStall), 32'd0);
        cyc(0, 0, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        // Write to r0 is consumed silently
        cyc(0, 1, 0, 0, 0, 5'd0, 32'h5555, 1, 5'd4, 32'h44);
        check_eq("r0_no_write", 32'(RfWrite), 32'd0);
        cyc(0, 0, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        // Reset while stalled abandons the secondary request
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 5'd2, 32'h2, 1, 5'd6, 32'h66);
        check_eq("stall_before_rst", 32'(PipeStall), 32'd1);
        cyc(1, 1, 0, 0, 0, 5'd2, 32'h2, 1, 5'd6, 32'h66);
        check_eq("rst_stall_drop", 32'(PipeStall), 32'd0);
        cyc(0, 0, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        // Withdrawal restarts the wait count
        cyc(0, 1, 0, 0, 0, 5'd1, 32'h1, 1, 5'd8, 32'h88);
        cyc(0, 1, 0, 0, 0, 5'd1, 32'h1, 1, 5'd8, 32'h88);
        cyc(0, 1, 0, 0, 0, 5'd1, 32'h1, 0, 5'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, 0, 5'd1, 32'h1, 1, 5'd8, 32'h88);
            if (i == 2) check_eq("no_early_stall", 32'(PipeStall), 32'd0);
        end
        check_eq("stall_after_restart", 32'(PipeStall), 32'd1);
        cyc(0, 0, 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

        // Random traffic; the requester holds its payload until transferred or withdrawn
        for (int i = 0; i < 3000; i++) begin
            bit          r_rst, r_prw, r_pcm, r_pmn, r_pz;
            logic [4:0]  r_pa;
            logic [31:0] r_pd;
            if (!c_sv || m_xfer) begin
                c_sv = ($urandom_range(0, 3) != 0);
                c_sa = 5'($urandom);
                c_sd = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                c_sv = 1'b0;
            end
            r_rst = ($urandom_range(0, 99) == 0);
            r_prw = ($urandom_range(0, 9) < 8);
            r_pcm = ($urandom_range(0, 2) == 0);
            r_pmn = 1'($urandom);
            r_pz  = 1'($urandom);
            r_pa  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            r_pd  = $urandom;
            cyc(r_rst, r_prw, r_pcm, r_pmn, r_pz, r_pa, r_pd, c_sv, c_sa, c_sd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
